fir_interp: RTL and testbench
=============================

FIR_INTERP -- requirements
Module: fir_interp

Interface
REQ-001 Parameter DATA_WIDTH, 32, sample and coefficient width (signed two's complement).
REQ-002 Parameter TAPS, 32, prototype filter length; TAPS SHALL be an integer multiple of INTERP.
REQ-003 Parameter INTERP, 4, interpolation factor (outputs per input sample).
REQ-004 Parameter FRAC_BITS, 10, fixed-point fraction bits of COEFF (Q-format scale 2^FRAC_BITS).
REQ-005 Parameter COEFF, TAPS x DATA_WIDTH signed array, defaults to the team's 32-tap lowpass set, index 0 first.
REQ-006 clock  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 x_in  input  DATA_WIDTH  input sample from the upstream FIFO, valid whenever x_in_empty=0.
REQ-009 x_in_rd_en  output  1  pop strobe to the upstream FIFO, one sample per asserted cycle.
REQ-010 x_in_empty  input  1  upstream FIFO empty.
REQ-011 y_out  output  DATA_WIDTH  interpolated output sample, valid only when y_out_wr_en=1.
REQ-012 y_out_wr_en  output  1  push strobe to the downstream FIFO.
REQ-013 y_out_full  input  1  downstream FIFO full.

Function
REQ-014 Block SHALL hold a history of PH=TAPS/INTERP samples h[0..PH-1], h[0] newest.
REQ-015 Output for phase p (0..INTERP-1) SHALL be sum over k=0..PH-1 of DEQ(COEFF[k*INTERP+p] * h[k]).
REQ-016 DEQ(v): full-width signed product; if v<0 result=(v+2^FRAC_BITS-1)>>>FRAC_BITS, else v>>>FRAC_BITS (truncate toward zero), then taken to DATA_WIDTH bits.
REQ-017 Accumulator SHALL be DATA_WIDTH bits, wrap on overflow, no saturation.
REQ-018 FSM states READ, COMPUTE, WRITE; reset state READ.
REQ-019 READ: if x_in_empty=0, assert x_in_rd_en for exactly one cycle, shift h (h[k]<=h[k-1], h[0]<=x_in), clear accumulator, phase<=0, tap<=0, go COMPUTE; else stay, rd_en=0.
REQ-020 COMPUTE: one MAC per cycle, tap 0..PH-1; after tap PH-1 go WRITE; exactly PH cycles per phase.
REQ-021 WRITE: if y_out_full=0, assert y_out_wr_en one cycle with y_out=accumulator; then if phase=INTERP-1 go READ, else phase++, tap<=0, accumulator<=0, go COMPUTE.
REQ-022 WRITE with y_out_full=1: hold state, accumulator and y_out stable, y_out_wr_en=0, indefinitely.
REQ-023 x_in_rd_en SHALL never assert outside READ; y_out_wr_en SHALL never assert outside WRITE; never both in one cycle.
REQ-024 Throughput: each input yields exactly INTERP outputs, in phase order 0..INTERP-1; unstalled output spacing PH+1 cycles; first output PH+1 cycles after the rd_en cycle.
REQ-025 x_in_empty transitions during COMPUTE/WRITE SHALL have no effect; y_out_full during READ/COMPUTE no effect.
REQ-026 y_out SHALL be 0 whenever y_out_wr_en=0 (no X on outputs).

Reset
REQ-027 Reset asserted SHALL immediately force state READ, h all zero, accumulator 0, phase 0, tap 0, x_in_rd_en=0, y_out_wr_en=0, y_out=0.
REQ-028 Reset mid-operation SHALL discard in-progress phases; no partial output after release; first post-reset output uses zero history except the newly read sample.
REQ-029 Block SHALL read no sample during the cycle reset deasserts only if x_in_empty=0 at the next rising edge.

Verification
REQ-030 Impulse: COEFF=0..31 (k), inputs 1024 then 7x 0 -> 32 outputs equal 0,1,2,...,31 in order.
REQ-031 DC: all COEFF=256 (0.25), constant input 4096 held -> after PH inputs, every output = 8*1024 = 8192.
REQ-032 Negative rounding: COEFF[0]=1, others 0, input -1 -> phase-0 output 0 (toward zero), phases 1..3 output 0; input -2048 -> phase-0 output -2.
REQ-033 Backpressure: hold y_out_full=1 for 20 cycles in WRITE -> y_out constant, no wr_en, no rd_en; release -> output sequence identical to unstalled run.
REQ-034 Starvation: x_in_empty=1 for 50 cycles between samples -> no strobes, FSM in READ, outputs unchanged on resume.
REQ-035 Reset during COMPUTE of phase 2 -> all outputs 0 same cycle; after release, input 1024 with impulse COEFF reproduces first 4 outputs 0,1,2,3.

Source files
------------

// File: rtl/fir_interp_if.sv
// rtl/fir_interp_if.sv - upstream pop / downstream push FIFO signals for fir_interp
interface fir_interp_if #(
  parameter int DATA_WIDTH = 32
);
  logic signed [DATA_WIDTH-1:0] x_in;
  logic                         x_in_rd_en;
  logic                         x_in_empty;
  logic signed [DATA_WIDTH-1:0] y_out;
  logic                         y_out_wr_en;
  logic                         y_out_full;

  modport master (
    output x_in, x_in_empty, y_out_full,
    input  x_in_rd_en, y_out, y_out_wr_en
  );

  modport slave (
    input  x_in, x_in_empty, y_out_full,
    output x_in_rd_en, y_out, y_out_wr_en
  );
endinterface

// File: rtl/fir_interp.sv
// rtl/fir_interp.sv - polyphase FIR interpolator, one MAC per cycle, FIFO in / FIFO out
module fir_interp #(
  parameter int DATA_WIDTH = 32,
  parameter int TAPS       = 32,
  parameter int INTERP     = 4,
  parameter int FRAC_BITS  = 10,
  parameter logic signed [DATA_WIDTH-1:0] COEFF [0:TAPS-1] = '{
    0, -3, -7, -10, -6, 8, 28, 44, 40, 0, -80, -170, -200, -100, 220, 760,
    760, 220, -100, -200, -170, -80, 0, 40, 44, 28, 8, -6, -10, -7, -3, 0
  }
) (
  input  logic         clock,
  input  logic         reset,
  fir_interp_if.slave  bus
);
  localparam int PH  = TAPS / INTERP;
  localparam int TW  = (PH > 1) ? $clog2(PH) : 1;
  localparam int PW  = (INTERP > 1) ? $clog2(INTERP) : 1;
  localparam int CIW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PRW = 2 * DATA_WIDTH;
  localparam logic signed [PRW-1:0] RND = PRW'((1 << FRAC_BITS) - 1);

  typedef enum logic [1:0] {READ, COMPUTE, WRITE} state_t;

  state_t                       state_q, state_d;
  logic signed [DATA_WIDTH-1:0] h_q [0:PH-1];
  logic signed [DATA_WIDTH-1:0] h_d [0:PH-1];
  logic signed [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [PW-1:0]                phase_q, phase_d;
  logic [TW-1:0]                tap_q, tap_d;

  logic [CIW-1:0]               coef_idx;
  logic signed [DATA_WIDTH-1:0] coef_sel;
  logic signed [DATA_WIDTH-1:0] h_sel;
  logic signed [PRW-1:0]        prod;
  logic signed [PRW-1:0]        prod_adj;
  logic signed [PRW-1:0]        deq_full;

  // Prototype tap k*INTERP+p feeds history slot k for phase p.
  assign coef_idx = CIW'(tap_q) * CIW'(INTERP) + CIW'(phase_q);
  assign coef_sel = COEFF[coef_idx];
  assign h_sel    = h_q[tap_q];
  assign prod     = coef_sel * h_sel;
  // Bias negatives before the arithmetic shift so the quotient truncates toward zero.
  assign prod_adj = prod[PRW-1] ? (prod + RND) : prod;
  assign deq_full = prod_adj >>> FRAC_BITS;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= READ;
      for (int k = 0; k < PH; k++) h_q[k] <= '0;
      acc_q   <= '0;
      phase_q <= '0;
      tap_q   <= '0;
    end else begin
      state_q <= state_d;
      for (int k = 0; k < PH; k++) h_q[k] <= h_d[k];
      acc_q   <= acc_d;
      phase_q <= phase_d;
      tap_q   <= tap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    for (int k = 0; k < PH; k++) h_d[k] = h_q[k];
    acc_d   = acc_q;
    phase_d = phase_q;
    tap_d   = tap_q;
    case (state_q)
      READ: begin
        if (!bus.x_in_empty) begin
          for (int k = PH - 1; k > 0; k--) h_d[k] = h_q[k-1];
          h_d[0]  = bus.x_in;
          acc_d   = '0;
          phase_d = '0;
          tap_d   = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        acc_d = acc_q + DATA_WIDTH'(deq_full);
        if (tap_q == TW'(PH - 1)) begin
          state_d = WRITE;
        end else begin
          tap_d = tap_q + TW'(1);
        end
      end
      WRITE: begin
        if (!bus.y_out_full) begin
          if (phase_q == PW'(INTERP - 1)) begin
            state_d = READ;
          end else begin
            phase_d = phase_q + PW'(1);
            tap_d   = '0;
            acc_d   = '0;
            state_d = COMPUTE;
          end
        end
      end
      default: state_d = READ;
    endcase
  end

  // Strobes are combinational; gating rd_en with reset keeps the pop quiet while held.
  always_comb begin
    bus.x_in_rd_en  = 1'b0;
    bus.y_out_wr_en = 1'b0;
    bus.y_out       = '0;
    case (state_q)
      READ:  bus.x_in_rd_en = !bus.x_in_empty && !reset;
      WRITE: begin
        bus.y_out_wr_en = !bus.y_out_full;
        bus.y_out       = bus.y_out_full ? '0 : acc_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_fir_interp.sv
// tb/tb_fir_interp.sv - directed bench: impulse, DC, rounding, backpressure, starvation, reset
module tb_fir_interp;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  localparam logic signed [31:0] C_IMP [0:31] = '{
    0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
    16, 17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31
  };
  localparam logic signed [31:0] C_DC  [0:31] = '{default: 256};
  localparam logic signed [31:0] C_NEG [0:31] = '{0: 1, default: 0};

  logic signed [31:0] xv [3] = '{0, 0, 0};
  logic               ev [3] = '{1'b1, 1'b1, 1'b1};
  logic               fv [3] = '{1'b0, 1'b0, 1'b0};
  logic               rd [3];
  logic               wr [3];
  logic signed [31:0] yv [3];

  fir_interp_if #(.DATA_WIDTH(32)) b0 ();
  fir_interp_if #(.DATA_WIDTH(32)) b1 ();
  fir_interp_if #(.DATA_WIDTH(32)) b2 ();

  assign b0.x_in = xv[0];  assign b0.x_in_empty = ev[0];  assign b0.y_out_full = fv[0];
  assign b1.x_in = xv[1];  assign b1.x_in_empty = ev[1];  assign b1.y_out_full = fv[1];
  assign b2.x_in = xv[2];  assign b2.x_in_empty = ev[2];  assign b2.y_out_full = fv[2];
  assign rd[0] = b0.x_in_rd_en;  assign wr[0] = b0.y_out_wr_en;  assign yv[0] = b0.y_out;
  assign rd[1] = b1.x_in_rd_en;  assign wr[1] = b1.y_out_wr_en;  assign yv[1] = b1.y_out;
  assign rd[2] = b2.x_in_rd_en;  assign wr[2] = b2.y_out_wr_en;  assign yv[2] = b2.y_out;

  fir_interp #(.DATA_WIDTH(32), .TAPS(32), .INTERP(4), .FRAC_BITS(10), .COEFF(C_IMP))
    u_imp (.clock(clock), .reset(reset), .bus(b0));
  fir_interp #(.DATA_WIDTH(32), .TAPS(32), .INTERP(4), .FRAC_BITS(10), .COEFF(C_DC))
    u_dc  (.clock(clock), .reset(reset), .bus(b1));
  fir_interp #(.DATA_WIDTH(32), .TAPS(32), .INTERP(4), .FRAC_BITS(10), .COEFF(C_NEG))
    u_neg (.clock(clock), .reset(reset), .bus(b2));

  int tests = 0;
  int failures = 0;
  int viol = 0;
  int cyc = 0;
  int rd_cyc = 0;
  int wr_cyc = 0;
  int prev_wr = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++)
      if ((rd[i] && wr[i]) || (!wr[i] && yv[i] !== 32'sd0)) viol <= viol + 1;
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic signed [31:0] v);
    bit seen = 1'b0;
    @(negedge clock);
    xv[i] = v;
    ev[i] = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      #1;
      if (rd[i]) begin
        seen = 1'b1;
        rd_cyc = cyc;
      end else begin
        @(negedge clock);
      end
    end
    if (!seen) check($sformatf("push%0d_rd_seen", i), 32'(seen), 32'sd1);
    @(posedge clock);
    #1 ev[i] = 1'b1;
  endtask

  task automatic expect_out(input int i, input logic signed [31:0] e, input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clock);
      #1;
      if (wr[i]) begin
        seen = 1'b1;
        prev_wr = wr_cyc;
        wr_cyc = cyc;
      end
    end
    if (!seen) check({tag, "_wr_seen"}, 32'(seen), 32'sd1);
    else       check(tag, yv[i], e);
  endtask

  initial begin
    int bad;
    // Reset state with a non-empty upstream FIFO: nothing may be popped.
    xv[0] = 32'sd1024;
    ev[0] = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("reset_rd_en", 32'(rd[0]), 32'sd0);
    check("reset_wr_en", 32'(wr[0]), 32'sd0);
    check("reset_y_out", yv[0], 32'sd0);
    ev[0] = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;

    // DC gain: 0.25 on every tap, history fills over PH inputs.
    for (int n = 1; n <= 9; n++) begin
      push(1, 32'sd4096);
      for (int p = 0; p < 4; p++)
        expect_out(1, 32'((n > 8 ? 8 : n) * 1024), $sformatf("dc_in%0d_ph%0d", n, p));
    end

    // Negative products truncate toward zero.
    push(2, -32'sd1);
    for (int p = 0; p < 4; p++) expect_out(2, 32'sd0, $sformatf("neg1_ph%0d", p));
    push(2, -32'sd2048);
    expect_out(2, -32'sd2, "neg2048_ph0");
    for (int p = 1; p < 4; p++) expect_out(2, 32'sd0, $sformatf("neg2048_ph%0d", p));
    push(2, 32'sd2047);
    expect_out(2, 32'sd1, "pos2047_ph0");

    // Impulse through the polyphase bank, with a stall and a starvation gap inserted.
    for (int n = 0; n < 8; n++) begin
      push(0, n == 0 ? 32'sd1024 : 32'sd0);
      for (int p = 0; p < 4; p++) begin
        expect_out(0, 32'(n * 4 + p), $sformatf("imp_in%0d_ph%0d", n, p));
        if (n == 1 && p == 0) check("first_out_latency", 32'(wr_cyc - rd_cyc), 32'sd9);
        if (n == 1 && p == 1) check("out_spacing", 32'(wr_cyc - prev_wr), 32'sd9);
        if (n == 0 && p == 0) begin
          @(posedge clock);
          #1 fv[0] = 1'b1;
          bad = 0;
          for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            #1;
            if (rd[0] || wr[0] || yv[0] !== 32'sd0) bad++;
          end
          check("stall_quiet", 32'(bad), 32'sd0);
          @(posedge clock);
          #1 fv[0] = 1'b0;
        end
      end
      if (n == 2) begin
        bad = 0;
        for (int c = 0; c < 50; c++) begin
          @(negedge clock);
          #1;
          if (rd[0] || wr[0]) bad++;
        end
        check("starve_quiet", 32'(bad), 32'sd0);
      end
    end

    // Reset while computing phase 2; stale history must not leak afterwards.
    push(0, 32'sd1024);
    expect_out(0, 32'sd0, "pre_rst_ph0");
    expect_out(0, 32'sd1, "pre_rst_ph1");
    repeat (3) @(negedge clock);
    xv[0] = 32'sd7;
    ev[0] = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_rd_en", 32'(rd[0]), 32'sd0);
    check("midrst_wr_en", 32'(wr[0]), 32'sd0);
    check("midrst_y_out", yv[0], 32'sd0);
    ev[0] = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    push(0, 32'sd1024);
    for (int p = 0; p < 4; p++) begin
      expect_out(0, 32'(p), $sformatf("post_rst_ph%0d", p));
      if (p == 0) check("post_rst_latency", 32'(wr_cyc - rd_cyc), 32'sd9);
    end

    repeat (2) @(negedge clock);
    check("protocol_violations", 32'(viol), 32'sd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
